// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes,
// and the frame parity helper.
package ps2_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_RTS       = 3'd2;
   localparam logic [2:0] ST_SHIFT     = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

   localparam int unsigned CNT_W = 21;

   // PS/2 frames carry odd parity over the 8 data bits.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Synchronizer and falling-edge detector for one PS/2 line. The clear input
// flushes the edge history so our own drive edges are not seen as device clocks.
module ps2_line_sync #(
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic line_i,
   output logic level_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], line_i};
      level_o = sync_q[SYNC_STAGES-1];
      prev_d  = clear ? 1'b0 : level_o;
      fall_o  = prev_q & ~level_o;
   end

   // Lines idle high, so the chain resets to ones and no edge is reported.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, frame shift on device clocks,
// ACK check and timeout abort. Lines are driven open-drain through the *_oe outputs.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 10000,
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_ack_ok,
   output logic       tx_error
);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [8:0]       shreg_q, shreg_d;
   logic             ack_q, ack_d;
   logic             idle_seen_q, idle_seen_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             done_q, done_d;
   logic             ack_ok_q, ack_ok_d;
   logic             error_q, error_d;

   logic clk_s, clk_fall, data_s, data_fall_unused, sync_clear;

   assign sync_clear = (state_q == ST_INHIBIT) || (state_q == ST_RTS);

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .clear   (sync_clear),
      .line_i  (ps2_clk_i),
      .level_o (clk_s),
      .fall_o  (clk_fall)
   );

   ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
      .clk     (clk),
      .rst     (rst),
      .clear   (sync_clear),
      .line_i  (ps2_data_i),
      .level_o (data_s),
      .fall_o  (data_fall_unused)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      ack_d       = ack_q;
      idle_seen_d = idle_seen_q;
      clk_oe_d    = clk_oe_q;
      data_oe_d   = data_oe_q;
      ack_ok_d    = ack_ok_q;
      done_d      = 1'b0;
      error_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (tx_valid) begin
               shreg_d   = {odd_parity(tx_data), tx_data};
               bit_cnt_d = 4'd0;
               cnt_d     = '0;
               ack_ok_d  = 1'b0;
               clk_oe_d  = 1'b1;
               data_oe_d = 1'b0;
               state_d   = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_RTS;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RTS: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               // Ones shift in behind parity, so the 10th fall drives the stop bit (release).
               data_oe_d = ~shreg_q[0];
               shreg_d   = {1'b1, shreg_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_fall) begin
               ack_d       = ~data_s;
               idle_seen_d = 1'b0;
               state_d     = ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            cnt_d = cnt_q + 1'b1;
            if (clk_s && data_s) begin
               if (idle_seen_q) begin
                  done_d   = 1'b1;
                  ack_ok_d = ack_q;
                  state_d  = ST_IDLE;
               end else begin
                  idle_seen_d = 1'b1;
               end
            end else begin
               idle_seen_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (((state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE)) &&
          (cnt_q == TMO_LAST)) begin
         clk_oe_d  = 1'b0;
         data_oe_d = 1'b0;
         done_d    = 1'b0;
         error_d   = 1'b1;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= 4'd0;
         shreg_q     <= '0;
         ack_q       <= 1'b0;
         idle_seen_q <= 1'b0;
         clk_oe_q    <= 1'b0;
         data_oe_q   <= 1'b0;
         done_q      <= 1'b0;
         ack_ok_q    <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         ack_q       <= ack_d;
         idle_seen_q <= idle_seen_d;
         clk_oe_q    <= clk_oe_d;
         data_oe_q   <= data_oe_d;
         done_q      <= done_d;
         ack_ok_q    <= ack_ok_d;
         error_q     <= error_d;
      end
   end

   assign tx_ready    = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx_done     = done_q;
   assign tx_ack_ok   = ack_ok_q;
   assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on open-drain lines
// clocking at 1/40 of the system clock.
module tb_ps2_host_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_ack_ok, tx_error;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       ps2_clk_line, ps2_data_line;
   int         errors = 0;
   int         checks = 0;

   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (20),
      .TIMEOUT_CYCLES (500),
      .SYNC_STAGES    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .ps2_clk_i   (ps2_clk_line),
      .ps2_data_i  (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .busy        (busy),
      .tx_done     (tx_done),
      .tx_ack_ok   (tx_ack_ok),
      .tx_error    (tx_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // mode: 0 = ACK, 1 = NACK, 2 = silent after RTS, 3 = stop with clk low after 5th fall
   task automatic run_device(input int mode, output logic [9:0] frame, output int inh_len,
                             output logic start_oe);
      int guard;
      guard   = 0;
      frame   = '0;
      inh_len = 0;
      while (!ps2_clk_oe && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      while (ps2_clk_oe && inh_len < 1000) begin
         inh_len++;
         @(negedge clk);
      end
      start_oe = ps2_data_oe;
      if (mode == 2) return;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         dev_clk_low = 1'b1;
         repeat (20) @(negedge clk);
         if (mode == 3 && k == 4) return;
         dev_clk_low = 1'b0;
         frame[k] = ps2_data_line;
         repeat (20) @(negedge clk);
      end
      dev_data_low = (mode == 0);
      dev_clk_low  = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (2) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic wait_done(output logic seen, output logic ack, output logic width_ok);
      int n;
      n = 0;
      while (!tx_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      seen = tx_done;
      ack  = tx_ack_ok;
      @(negedge clk);
      width_ok = !tx_done;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [9:0] fr;
      int         inh;
      int         n;
      logic       st, seen, ack, w, saw_done;

      repeat (3) @(negedge clk);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_done", tx_done, 0);
      check("rst_ack_ok", tx_ack_ok, 0);
      check("rst_error", tx_error, 0);
      rst = 1'b1;

      // Set-LED command with ACK
      send_byte(8'hED);
      check("busy_after_accept", busy, 1);
      run_device(0, fr, inh, st);
      check("inhibit_len", inh, 20);
      check("start_bit_oe", st, 1);
      check("frame_ed", fr, 10'h3ED);
      wait_done(seen, ack, w);
      check("done_ed", seen, 1);
      check("ack_ed", ack, 1);
      check("done_width_ed", w, 1);
      check("ready_after_ed", tx_ready, 1);

      // Parity 0 and parity 1 frames
      send_byte(8'h07);
      run_device(0, fr, inh, st);
      check("frame_07", fr, 10'h207);
      wait_done(seen, ack, w);
      check("ack_07", ack, 1);
      send_byte(8'h00);
      run_device(0, fr, inh, st);
      check("frame_00", fr, 10'h300);
      wait_done(seen, ack, w);
      check("ack_00", ack, 1);

      // Silent device: timeout abort
      send_byte(8'hA5);
      run_device(2, fr, inh, st);
      n = 0;
      saw_done = 1'b0;
      while (!tx_error && n < 700) begin
         @(negedge clk);
         n++;
         if (tx_done) saw_done = 1'b1;
      end
      check("timeout_delay", n, 500);
      check("timeout_clk_oe", ps2_clk_oe, 0);
      check("timeout_data_oe", ps2_data_oe, 0);
      check("timeout_no_done", saw_done, 0);
      check("timeout_ready", tx_ready, 1);
      @(negedge clk);
      check("error_width", tx_error, 0);

      // NACK
      send_byte(8'hED);
      run_device(1, fr, inh, st);
      check("frame_nack", fr, 10'h3ED);
      wait_done(seen, ack, w);
      check("done_nack", seen, 1);
      check("ack_nack", ack, 0);

      // tx_valid during SHIFT is dropped
      send_byte(8'hED);
      fork
         run_device(0, fr, inh, st);
         begin
            repeat (150) @(negedge clk);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            @(negedge clk);
            check("ready_while_busy", tx_ready, 0);
            tx_valid = 1'b0;
         end
      join
      check("frame_ed_again", fr, 10'h3ED);
      wait_done(seen, ack, w);
      check("done_ed_again", seen, 1);
      repeat (60) @(negedge clk);
      check("no_queued_frame", busy, 0);
      check("ack_ok_holds", tx_ack_ok, 1);

      // Asynchronous reset mid-frame, during bit 4 (bit 4 of 0xED is 0)
      send_byte(8'hED);
      run_device(3, fr, inh, st);
      check("bit4_drive", ps2_data_oe, 1);
      #3 rst = 1'b0;
      #1;
      check("arst_clk_oe", ps2_clk_oe, 0);
      check("arst_data_oe", ps2_data_oe, 0);
      check("arst_ready", tx_ready, 1);
      dev_clk_low = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_rst", tx_ready, 1);
      send_byte(8'h02);
      run_device(0, fr, inh, st);
      check("frame_02", fr, 10'h202);
      wait_done(seen, ack, w);
      check("done_02", seen, 1);
      check("ack_02", ack, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
